// File: rtl/sprite_line_selector.sv
// Per-line object selector: scans OAM once per line, keeps up to MAX_SPR objects
// covering the line, and reports the lowest-slot object whose X matches the pixel X.
//
// state  | meaning
// S_IDLE | no scan running; slots hold the last line's objects for rendering
// S_SCAN | issuing OAM reads and evaluating returned entries one per cycle
module sprite_line_selector #(
    parameter int N_OAM   = 40,
    parameter int MAX_SPR = 10,
    parameter int W_Y     = 8,
    parameter int W_X     = 8,
    localparam int IW     = $clog2(N_OAM),
    localparam int SW     = $clog2(MAX_SPR),
    localparam int CW     = $clog2(MAX_SPR + 1)
) (
    input  logic           clk1,
    input  logic           reset_video,
    input  logic           scan_start,
    input  logic [W_Y-1:0] ly,
    input  logic           tall,
    input  logic           obj_en,
    output logic           oam_rd,
    output logic [IW-1:0]  oam_addr,
    input  logic [W_Y-1:0] oam_y,
    input  logic [W_X-1:0] oam_x,
    output logic           scanning,
    output logic           scan_done,
    output logic [CW-1:0]  spr_count,
    output logic           overflow,
    input  logic           render,
    input  logic [W_X-1:0] px,
    output logic           hit,
    output logic [SW-1:0]  hit_slot,
    output logic [IW-1:0]  hit_idx,
    output logic [3:0]     hit_line,
    input  logic           fetch_done
);

    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t r_state, w_state_next;

    logic           r_rd, r_ev, r_tall, r_ovf, r_done;
    logic [IW-1:0]  r_addr, r_ev_idx;
    logic [W_Y-1:0] r_ly;
    logic [CW-1:0]  r_count;

    logic [MAX_SPR-1:0] r_valid, w_valid_n;
    logic [IW-1:0]      r_sidx  [MAX_SPR];
    logic [IW-1:0]      w_idx_n [MAX_SPR];
    logic [W_X-1:0]     r_sx    [MAX_SPR];
    logic [W_X-1:0]     w_x_n   [MAX_SPR];
    logic [3:0]         r_sline [MAX_SPR];
    logic [3:0]         w_line_n[MAX_SPR];

    logic           r_hit, w_hit;
    logic [SW-1:0]  r_hit_slot, w_hit_slot;
    logic [IW-1:0]  r_hit_idx, w_hit_idx;
    logic [3:0]     r_hit_line, w_hit_line;

    logic [W_Y-1:0] w_d;
    logic           w_match, w_full, w_scan_end;

    // Row distance with a 16-line offset so objects partly above the screen still match.
    assign w_d        = r_ly + W_Y'(16) - oam_y;
    assign w_match    = r_ev && (r_tall ? (w_d < W_Y'(16)) : (w_d < W_Y'(8)));
    assign w_full     = (r_count == CW'(MAX_SPR));
    assign w_scan_end = (r_state == S_SCAN) && r_ev && (r_ev_idx == IW'(N_OAM - 1)) && !scan_start;

    always_ff @(posedge clk1) begin
        if (reset_video) r_state <= S_IDLE;
        else             r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (scan_start)      w_state_next = S_SCAN;
        else if (w_scan_end) w_state_next = S_IDLE;
    end

    // Next slot contents; hit selection looks at these so a retire in this cycle is honoured.
    always_comb begin
        w_valid_n = r_valid;
        w_idx_n   = r_sidx;
        w_x_n     = r_sx;
        w_line_n  = r_sline;
        if (scan_start) begin
            w_valid_n = '0;
        end else begin
            if (fetch_done && r_hit) w_valid_n[r_hit_slot] = 1'b0;
            if (w_match && !w_full) begin
                for (int i = 0; i < MAX_SPR; i++) begin
                    if (CW'(i) == r_count) begin
                        w_valid_n[i] = 1'b1;
                        w_idx_n[i]   = r_ev_idx;
                        w_x_n[i]     = oam_x;
                        w_line_n[i]  = w_d[3:0];
                    end
                end
            end
        end
    end

    always_comb begin
        w_hit      = 1'b0;
        w_hit_slot = '0;
        w_hit_idx  = '0;
        w_hit_line = '0;
        if (render && obj_en) begin
            for (int i = MAX_SPR - 1; i >= 0; i--) begin
                if (w_valid_n[i] && (w_x_n[i] == px)) begin
                    w_hit      = 1'b1;
                    w_hit_slot = SW'(i);
                    w_hit_idx  = w_idx_n[i];
                    w_hit_line = w_line_n[i];
                end
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (reset_video) begin
            r_rd       <= 1'b0;
            r_addr     <= '0;
            r_ev       <= 1'b0;
            r_ev_idx   <= '0;
            r_ly       <= '0;
            r_tall     <= 1'b0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= '0;
            r_hit      <= 1'b0;
            r_hit_slot <= '0;
            r_hit_idx  <= '0;
            r_hit_line <= '0;
            for (int i = 0; i < MAX_SPR; i++) begin
                r_sidx[i]  <= '0;
                r_sx[i]    <= '0;
                r_sline[i] <= '0;
            end
        end else begin
            r_done     <= w_scan_end;
            r_valid    <= w_valid_n;
            r_sidx     <= w_idx_n;
            r_sx       <= w_x_n;
            r_sline    <= w_line_n;
            r_hit      <= w_hit;
            r_hit_slot <= w_hit_slot;
            r_hit_idx  <= w_hit_idx;
            r_hit_line <= w_hit_line;
            if (scan_start) begin
                r_ly    <= ly;
                r_tall  <= tall;
                r_addr  <= '0;
                r_rd    <= 1'b1;
                r_ev    <= 1'b0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_ev     <= r_rd;
                r_ev_idx <= r_addr;
                if (r_rd) begin
                    if (r_addr == IW'(N_OAM - 1)) r_rd   <= 1'b0;
                    else                          r_addr <= r_addr + IW'(1);
                end
                if (w_match) begin
                    if (w_full) r_ovf   <= 1'b1;
                    else        r_count <= r_count + CW'(1);
                end
            end
        end
    end

    assign oam_rd     = r_rd;
    assign oam_addr   = r_addr;
    assign scanning   = (r_state == S_SCAN);
    assign scan_done  = r_done;
    assign spr_count  = r_count;
    assign overflow   = r_ovf;
    assign hit        = r_hit;
    assign hit_slot   = r_hit_slot;
    assign hit_idx    = r_hit_idx;
    assign hit_line   = r_hit_line;

endmodule

// File: tb/tb_sprite_line_selector.sv
// Self-checking bench for sprite_line_selector: directed scenarios plus randomized
// scans and render sequences compared against a list-based object model.
module tb_sprite_line_selector;
    localparam int N   = 40;
    localparam int MAX = 10;

    logic       clk1 = 0;
    logic       reset_video, scan_start, tall, obj_en, render, fetch_done;
    logic [7:0] ly, oam_y, oam_x, px;
    logic       oam_rd, scanning, scan_done, overflow, hit;
    logic [5:0] oam_addr, hit_idx;
    logic [3:0] spr_count, hit_slot, hit_line;

    int checks = 0;
    int errors = 0;

    int mem_y [N];
    int mem_x [N];

    // Object model: slots as an ordered list filled from OAM in index order.
    int m_idx [MAX];
    int m_x   [MAX];
    int m_line[MAX];
    bit m_valid[MAX];
    int m_count;
    bit m_ovf;
    bit e_hit;
    int e_slot;

    sprite_line_selector #(.N_OAM(N), .MAX_SPR(MAX), .W_Y(8), .W_X(8)) dut (
        .clk1(clk1), .reset_video(reset_video), .scan_start(scan_start), .ly(ly),
        .tall(tall), .obj_en(obj_en), .oam_rd(oam_rd), .oam_addr(oam_addr),
        .oam_y(oam_y), .oam_x(oam_x), .scanning(scanning), .scan_done(scan_done),
        .spr_count(spr_count), .overflow(overflow), .render(render), .px(px),
        .hit(hit), .hit_slot(hit_slot), .hit_idx(hit_idx), .hit_line(hit_line),
        .fetch_done(fetch_done)
    );

    always #5 clk1 = ~clk1;

    // OAM returns data one cycle after the read; garbage otherwise to expose timing slips.
    always @(posedge clk1) begin
        if (oam_rd) begin
            oam_y <= 8'(mem_y[oam_addr]);
            oam_x <= 8'(mem_x[oam_addr]);
        end else begin
            oam_y <= 8'($urandom);
            oam_x <= 8'($urandom);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    function automatic void clear_oam();
        for (int e = 0; e < N; e++) begin
            mem_y[e] = 0;
            mem_x[e] = 255;
        end
    endfunction

    function automatic void model_scan(int l, bit t);
        int d;
        m_count = 0;
        m_ovf   = 0;
        e_hit   = 0;
        e_slot  = 0;
        for (int s = 0; s < MAX; s++) m_valid[s] = 0;
        for (int e = 0; e < N; e++) begin
            d = (l + 16 - mem_y[e] + 256) % 256;
            if (d < (t ? 16 : 8)) begin
                if (m_count < MAX) begin
                    m_idx[m_count]   = e;
                    m_x[m_count]     = mem_x[e];
                    m_line[m_count]  = d % 16;
                    m_valid[m_count] = 1;
                    m_count++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endfunction

    // Drives one render cycle and advances the model; caller compares after it returns.
    task automatic render_step(input int p, input bit r, input bit en, input bit fd);
        px = 8'(p); render = r; obj_en = en; fetch_done = fd;
        if (fd && e_hit) m_valid[e_slot] = 0;
        e_hit = 0;
        if (r && en) begin
            for (int i = MAX - 1; i >= 0; i--) begin
                if (m_valid[i] && m_x[i] == p) begin
                    e_hit = 1;
                    e_slot = i;
                end
            end
        end
        @(negedge clk1);
        fetch_done = 0;
    endtask

    task automatic do_scan(input int l, input bit t, output int lat, output int cnt,
                           output bit ov, output bit rd1, output int a1, output bit sc1);
        ly = 8'(l); tall = t; scan_start = 1;
        @(negedge clk1);
        scan_start = 0;
        rd1 = oam_rd; a1 = oam_addr; sc1 = scanning;
        lat = -1; cnt = -1; ov = 0;
        for (int k = 1; k <= 200; k++) begin
            if (scan_done) begin
                lat = k; cnt = spr_count; ov = overflow;
                break;
            end
            @(negedge clk1);
        end
        model_scan(l, t);
    endtask

    task automatic test_reset();
        int k;
        reset_video = 1; scan_start = 0; ly = 0; tall = 0; obj_en = 0;
        render = 0; px = 0; fetch_done = 0;
        repeat (3) @(negedge clk1);
        checks++;
        if (oam_rd !== 0 || oam_addr !== 0 || scanning !== 0 || scan_done !== 0 || overflow !== 0) begin
            errors++;
            $display("FAIL reset_ctrl got rd=%0b addr=%0d scanning=%0b done=%0b ovf=%0b exp all 0",
                     oam_rd, oam_addr, scanning, scan_done, overflow);
        end
        checks++;
        if (hit !== 0 || spr_count !== 0 || hit_slot !== 0 || hit_idx !== 0 || hit_line !== 0) begin
            errors++;
            $display("FAIL reset_data got hit=%0b cnt=%0d slot=%0d idx=%0d line=%0d exp all 0",
                     hit, spr_count, hit_slot, hit_idx, hit_line);
        end
        reset_video = 0;
        @(negedge clk1);
        // Reset mid-scan with three slots already filled.
        clear_oam();
        mem_y[3] = 16; mem_x[3] = 20;
        mem_y[7] = 12; mem_x[7] = 30;
        mem_y[9] = 9;  mem_x[9] = 40;
        ly = 0; tall = 0; scan_start = 1;
        @(negedge clk1);
        scan_start = 0;
        for (k = 1; k < 15; k++) @(negedge clk1);
        checks++;
        if (spr_count !== 3 || scanning !== 1) begin
            errors++;
            $display("FAIL midscan_pre got cnt=%0d scanning=%0b exp cnt=3 scanning=1", spr_count, scanning);
        end
        reset_video = 1; render = 1; obj_en = 1; px = 20;
        @(negedge clk1);
        reset_video = 0;
        checks++;
        if (scanning !== 0 || spr_count !== 0 || hit !== 0 || oam_rd !== 0) begin
            errors++;
            $display("FAIL midscan_reset got scanning=%0b cnt=%0d hit=%0b rd=%0b exp all 0",
                     scanning, spr_count, hit, oam_rd);
        end
        @(negedge clk1);
        checks++;
        if (hit !== 0) begin
            errors++;
            $display("FAIL reset_slots_cleared got hit=%0b exp 0", hit);
        end
        render = 0; obj_en = 0;
        @(negedge clk1);
    endtask

    task automatic test_basic_scan();
        int lat, cnt, a1;
        bit ov, rd1, sc1;
        int pxs[4] = '{20, 30, 40, 21};
        clear_oam();
        mem_y[3] = 16; mem_x[3] = 20;
        mem_y[7] = 12; mem_x[7] = 30;
        mem_y[9] = 9;  mem_x[9] = 40;
        do_scan(0, 0, lat, cnt, ov, rd1, a1, sc1);
        checks++;
        if (rd1 !== 1 || a1 != 0 || sc1 !== 1) begin
            errors++;
            $display("FAIL basic_first_read got rd=%0b addr=%0d scanning=%0b exp 1 0 1", rd1, a1, sc1);
        end
        checks++;
        if (lat != 42 || cnt != 3 || ov !== 0) begin
            errors++;
            $display("FAIL basic_done got lat=%0d cnt=%0d ovf=%0b exp lat=42 cnt=3 ovf=0", lat, cnt, ov);
        end
        checks++;
        if (scanning !== 0) begin
            errors++;
            $display("FAIL basic_scanning_end got %0b exp 0", scanning);
        end
        @(negedge clk1);
        checks++;
        if (scan_done !== 0) begin
            errors++;
            $display("FAIL basic_done_pulse got %0b exp 0", scan_done);
        end
        foreach (pxs[i]) begin
            render_step(pxs[i], 1, 1, 0);
            checks++;
            if (hit !== e_hit || (e_hit && (hit_slot !== e_slot || hit_idx !== m_idx[e_slot] || hit_line !== m_line[e_slot]))) begin
                errors++;
                $display("FAIL basic_hit px=%0d got hit=%0b slot=%0d idx=%0d line=%0d exp hit=%0b slot=%0d idx=%0d line=%0d",
                         pxs[i], hit, hit_slot, hit_idx, hit_line, e_hit, e_slot, m_idx[e_slot], m_line[e_slot]);
            end
        end
        render_step(40, 0, 0, 0);
        checks++;
        if (hit !== 0 || m_idx[2] != 9 || m_line[2] != 7) begin
            errors++;
            $display("FAIL basic_slot2 got hit=%0b model idx=%0d line=%0d exp hit=0 idx=9 line=7", hit, m_idx[2], m_line[2]);
        end
    endtask

    task automatic test_height();
        int lat, cnt, a1;
        bit ov, rd1, sc1;
        clear_oam();
        mem_y[5] = 18; mem_x[5] = 77;
        do_scan(10, 0, lat, cnt, ov, rd1, a1, sc1);
        checks++;
        if (lat != 42 || cnt != 0) begin
            errors++;
            $display("FAIL height8 got lat=%0d cnt=%0d exp lat=42 cnt=0", lat, cnt);
        end
        do_scan(10, 1, lat, cnt, ov, rd1, a1, sc1);
        checks++;
        if (lat != 42 || cnt != 1) begin
            errors++;
            $display("FAIL height16 got lat=%0d cnt=%0d exp lat=42 cnt=1", lat, cnt);
        end
        render_step(77, 1, 1, 0);
        checks++;
        if (hit !== 1 || hit_slot !== 0 || hit_idx !== 5 || hit_line !== 8) begin
            errors++;
            $display("FAIL height16_hit got hit=%0b slot=%0d idx=%0d line=%0d exp 1 0 5 8",
                     hit, hit_slot, hit_idx, hit_line);
        end
        render_step(0, 0, 0, 0);
    endtask

    task automatic test_overflow();
        int lat, cnt, a1;
        bit ov, rd1, sc1;
        int k;
        clear_oam();
        for (int e = 0; e < 12; e++) begin
            mem_y[e] = 30; mem_x[e] = e;
        end
        do_scan(20, 0, lat, cnt, ov, rd1, a1, sc1);
        checks++;
        if (lat != 42 || cnt != 10 || ov !== 1) begin
            errors++;
            $display("FAIL ovf_done got lat=%0d cnt=%0d ovf=%0b exp lat=42 cnt=10 ovf=1", lat, cnt, ov);
        end
        for (int p = 0; p < 12; p++) begin
            render_step(p, 1, 1, 0);
            checks++;
            if (hit !== e_hit || (e_hit && (hit_slot !== e_slot || hit_idx !== m_idx[e_slot] || hit_line !== m_line[e_slot]))) begin
                errors++;
                $display("FAIL ovf_hit px=%0d got hit=%0b slot=%0d idx=%0d exp hit=%0b slot=%0d idx=%0d",
                         p, hit, hit_slot, hit_idx, e_hit, e_slot, m_idx[e_slot]);
            end
        end
        render_step(0, 0, 0, 0);
        checks++;
        if (overflow !== 1) begin
            errors++;
            $display("FAIL ovf_sticky got %0b exp 1", overflow);
        end
        ly = 200; tall = 0; scan_start = 1;
        @(negedge clk1);
        scan_start = 0;
        checks++;
        if (overflow !== 0 || spr_count !== 0) begin
            errors++;
            $display("FAIL ovf_cleared got ovf=%0b cnt=%0d exp 0 0", overflow, spr_count);
        end
        for (k = 0; k < 100 && !scan_done; k++) @(negedge clk1);
        checks++;
        if (scan_done !== 1) begin
            errors++;
            $display("FAIL ovf_rescan_done got %0b exp 1", scan_done);
        end
        model_scan(200, 0);
    endtask

    task automatic test_priority_retire();
        int lat, cnt, a1;
        bit ov, rd1, sc1;
        clear_oam();
        mem_y[2] = 16; mem_x[2] = 20;
        mem_y[4] = 15; mem_x[4] = 20;
        mem_y[6] = 14; mem_x[6] = 50;
        do_scan(0, 0, lat, cnt, ov, rd1, a1, sc1);
        render_step(20, 1, 1, 0);
        checks++;
        if (hit !== 1 || hit_slot !== 0 || hit_idx !== 2 || hit_line !== 0) begin
            errors++;
            $display("FAIL prio_first got hit=%0b slot=%0d idx=%0d line=%0d exp 1 0 2 0", hit, hit_slot, hit_idx, hit_line);
        end
        render_step(20, 1, 1, 1);
        checks++;
        if (hit !== 1 || hit_slot !== 1 || hit_idx !== 4 || hit_line !== 1) begin
            errors++;
            $display("FAIL retire_first got hit=%0b slot=%0d idx=%0d line=%0d exp 1 1 4 1", hit, hit_slot, hit_idx, hit_line);
        end
        render_step(20, 1, 1, 1);
        checks++;
        if (hit !== 0) begin
            errors++;
            $display("FAIL retire_second got hit=%0b exp 0", hit);
        end
        render_step(50, 1, 1, 1);
        checks++;
        if (hit !== 1 || hit_slot !== 2 || hit_idx !== 6 || hit_line !== 2) begin
            errors++;
            $display("FAIL retire_ignored got hit=%0b slot=%0d idx=%0d line=%0d exp 1 2 6 2", hit, hit_slot, hit_idx, hit_line);
        end
        render_step(50, 1, 0, 0);
        checks++;
        if (hit !== 0 || spr_count !== 3) begin
            errors++;
            $display("FAIL obj_en_gate got hit=%0b cnt=%0d exp 0 3", hit, spr_count);
        end
        render_step(0, 0, 0, 0);
    endtask

    task automatic test_restart();
        int first = -1;
        clear_oam();
        mem_y[3] = 16; mem_x[3] = 20;
        mem_y[20] = 60; mem_x[20] = 5;
        mem_y[25] = 66; mem_x[25] = 6;
        ly = 0; tall = 0; scan_start = 1;
        @(negedge clk1);
        scan_start = 0;
        for (int k = 1; k <= 80; k++) begin
            if (k == 20) begin
                ly = 50; scan_start = 1;
            end
            if (scan_done && first < 0) first = k;
            @(negedge clk1);
            scan_start = 0;
        end
        model_scan(50, 0);
        checks++;
        if (first != 62 || spr_count !== 2) begin
            errors++;
            $display("FAIL restart_done got first_done=%0d cnt=%0d exp 62 2", first, spr_count);
        end
        for (int p = 4; p <= 6; p++) begin
            render_step(p == 4 ? 20 : p, 1, 1, 0);
            checks++;
            if (hit !== e_hit || (e_hit && (hit_slot !== e_slot || hit_idx !== m_idx[e_slot] || hit_line !== m_line[e_slot]))) begin
                errors++;
                $display("FAIL restart_hit got hit=%0b slot=%0d idx=%0d line=%0d exp hit=%0b slot=%0d idx=%0d line=%0d",
                         hit, hit_slot, hit_idx, hit_line, e_hit, e_slot, m_idx[e_slot], m_line[e_slot]);
            end
        end
        render_step(0, 0, 0, 0);
    endtask

    task automatic test_random();
        int lat, cnt, a1, l, p;
        bit ov, rd1, sc1, t;
        for (int it = 0; it < 8; it++) begin
            l = $urandom_range(0, 255);
            t = 1'($urandom_range(0, 1));
            for (int e = 0; e < N; e++) begin
                if ($urandom_range(0, 2) != 0) mem_y[e] = (l + 16 - $urandom_range(0, 17)) % 256;
                else                           mem_y[e] = $urandom_range(0, 255);
                mem_x[e] = $urandom_range(0, 7);
            end
            do_scan(l, t, lat, cnt, ov, rd1, a1, sc1);
            checks++;
            if (lat != 42 || cnt != m_count || ov !== m_ovf) begin
                errors++;
                $display("FAIL rand_scan it=%0d got lat=%0d cnt=%0d ovf=%0b exp lat=42 cnt=%0d ovf=%0b",
                         it, lat, cnt, ov, m_count, m_ovf);
            end
            for (int s = 0; s < 40; s++) begin
                p = $urandom_range(0, 7);
                render_step(p, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0);
                checks++;
                if (hit !== e_hit || (e_hit && (hit_slot !== e_slot || hit_idx !== m_idx[e_slot] || hit_line !== m_line[e_slot]))) begin
                    errors++;
                    $display("FAIL rand_hit it=%0d px=%0d got hit=%0b slot=%0d idx=%0d line=%0d exp hit=%0b slot=%0d idx=%0d line=%0d",
                             it, p, hit, hit_slot, hit_idx, hit_line, e_hit, e_slot, m_idx[e_slot], m_line[e_slot]);
                end
            end
            render_step(0, 0, 0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_height();
        test_overflow();
        test_priority_retire();
        test_restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
